// File: rtl/vc_test_tag_pkg.sv
// Shared definitions for the tag shuffler and tag sink: tag field layout, LFSR taps, helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package vc_test_tag_pkg;

    // Default tag field layout, shared with the tag sink so both agree on where the tag lives.
    localparam int unsigned TAG_NBITS_DFLT  = 2;
    localparam int unsigned TAG_OFFSET_DFLT = 8;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Pull an nbits-wide field starting at offset out of a message (zero-extended to 32 bits).
    function automatic logic [31:0] tag_extract(input logic [31:0] msg,
                                                input int unsigned offset,
                                                input int unsigned nbits);
        return (msg >> offset) & ((32'd1 << nbits) - 32'd1);
    endfunction

    // One step of the 8-bit Fibonacci LFSR: shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vc_test_tag_queue.sv
// Single-clock circular-buffer FIFO holding the messages of one tag.
// Latency: an entry pushed at edge k is visible on head after edge k (selectable from k+1).
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps count.
module vc_test_tag_queue #(
    parameter int unsigned p_msg_nbits = 10,
    parameter int unsigned p_depth     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [p_msg_nbits-1:0] push_msg,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [p_msg_nbits-1:0] head
);

    localparam int unsigned AW = $clog2(p_depth);

    logic [p_msg_nbits-1:0] mem [p_depth];
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            count;
    logic                   push_ok;
    logic                   pop_ok;

    assign full    = (count == (AW+1)'(p_depth));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array: written at the tail, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_msg;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vc_test_tag_shuffler.sv
// Splits an in-order tagged stream into per-tag queues and re-emits it shuffled across tags.
// Latency: minimum 2 edges (accept at k, visible on out_msg after k+1); 1 msg/cycle steady state.
// Backpressure: in_rdy drops when the addressed tag queue is full; out_val/out_msg hold while !out_rdy.
module vc_test_tag_shuffler
    import vc_test_tag_pkg::*;
#(
    parameter int unsigned p_msg_nbits   = 10,
    parameter int unsigned p_tag_nbits   = TAG_NBITS_DFLT,
    parameter int unsigned p_tag_offset  = TAG_OFFSET_DFLT,
    parameter int unsigned p_queue_depth = 4,
    parameter logic [7:0]  p_lfsr_seed   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_msg_nbits-1:0] out_msg
);

    localparam int unsigned NQ = 1 << p_tag_nbits;

    logic [p_tag_nbits-1:0] in_tag;
    logic [NQ-1:0]          q_full;
    logic [NQ-1:0]          q_empty;
    logic [NQ-1:0]          q_push;
    logic [NQ-1:0]          q_pop;
    logic [p_msg_nbits-1:0] q_head [NQ];
    logic [7:0]             lfsr;
    logic                   load;
    logic                   sel_vld;
    logic [p_tag_nbits-1:0] sel_idx;

    assign in_tag = p_tag_nbits'(tag_extract(32'(in_msg), p_tag_offset, p_tag_nbits));
    assign in_rdy = !q_full[in_tag];

    // Output register accepts a new message when it is empty or being drained this cycle.
    assign load = !out_val || out_rdy;

    // Tag demux: route the accepted message to its own queue only.
    always_comb begin
        q_push         = '0;
        q_push[in_tag] = in_val && in_rdy;
    end

    // Rotating priority: first non-empty queue at or after the LFSR-chosen start index.
    // Scanning from the far end down lets the nearest hit win without a break.
    always_comb begin
        logic [p_tag_nbits-1:0] idx;
        idx     = '0;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = NQ - 1; k >= 0; k--) begin
            idx = lfsr[p_tag_nbits-1:0] + p_tag_nbits'(k);
            if (!q_empty[idx]) begin
                sel_vld = 1'b1;
                sel_idx = idx;
            end
        end
    end

    // Pop only the selected queue, and only when the output register is loading.
    always_comb begin
        q_pop = '0;
        if (load && sel_vld) begin
            q_pop[sel_idx] = 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NQ; g++) begin : g_queue
            vc_test_tag_queue #(
                .p_msg_nbits (p_msg_nbits),
                .p_depth     (p_queue_depth)
            ) u_queue (
                .clk      (clk),
                .reset    (reset),
                .push     (q_push[g]),
                .push_msg (in_msg),
                .pop      (q_pop[g]),
                .full     (q_full[g]),
                .empty    (q_empty[g]),
                .head     (q_head[g])
            );
        end
    endgenerate

    // Output register: reload from the selected head, or go idle keeping the last message.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
        end else if (load) begin
            out_val <= sel_vld;
            if (sel_vld) begin
                out_msg <= q_head[sel_idx];
            end
        end
    end

    // Free-running LFSR so the shuffle pattern depends only on seed and cycle count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= p_lfsr_seed;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: tb/tb_vc_test_tag_shuffler.sv
module tb_vc_test_tag_shuffler;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [9:0] in_msg;
    logic       out_val;
    logic       out_rdy;
    logic [9:0] out_msg;

    vc_test_tag_shuffler #(
        .p_msg_nbits   (10),
        .p_tag_nbits   (2),
        .p_tag_offset  (8),
        .p_queue_depth (4),
        .p_lfsr_seed   (8'hA5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: four plain queues, the output slot, and the LFSR value.
    logic [9:0] mq [4][$];
    logic       mv;
    logic [9:0] mmsg;
    logic [7:0] ml;

    logic [9:0] obs [$];
    logic [10:0] trace [$];
    bit         rec;
    bit         last_xfer;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    function automatic logic [7:0] ref_lfsr(input logic [7:0] l);
        int fb;
        fb = ((int'(l) >> 7) ^ (int'(l) >> 5) ^ (int'(l) >> 4) ^ (int'(l) >> 3)) & 1;
        return 8'(((int'(l) << 1) | fb) & 255);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        mv   = 1'b0;
        mmsg = '0;
        ml   = 8'hA5;
    endtask

    function automatic int pos(input logic [9:0] x);
        foreach (obs[i]) if (obs[i] === x) return i;
        return -1;
    endfunction

    // One clock: drive inputs, check in_rdy, advance the model, check outputs after the edge.
    task automatic cycle(input logic v, input logic [9:0] m, input logic r);
        int  t;
        int  s;
        bit  found;
        bit  acc;
        in_val  = v;
        in_msg  = m;
        out_rdy = r;
        #1;
        t = int'(m[9:8]);
        chk("in_rdy", in_rdy, mq[t].size() < 4);
        acc = v && (mq[t].size() < 4);
        last_xfer = out_val && out_rdy;
        if (last_xfer) obs.push_back(out_msg);
        if (!mv || r) begin
            found = 0;
            s = int'(ml[1:0]);
            for (int k = 0; k < 4; k++) begin
                if (!found && mq[(s + k) % 4].size() > 0) begin
                    mmsg  = mq[(s + k) % 4].pop_front();
                    found = 1;
                end
            end
            mv = found;
        end
        if (acc) mq[t].push_back(m);
        ml = ref_lfsr(ml);
        @(posedge clk);
        #1;
        chk("out_val", out_val, mv);
        chk("out_msg", out_msg, mmsg);
        if (rec) trace.push_back({out_val, out_msg});
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        in_val  = 1'b0;
        in_msg  = '0;
        out_rdy = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [9:0] mix [8];
    logic       st_v [300];
    logic [9:0] st_m [300];
    logic       st_r [300];
    logic [10:0] trace1 [$];

    initial begin
        int cnt;
        int diff;
        logic [9:0] held;
        logic       pv;
        logic       pacc;
        rec = 0;

        // Reset state
        do_reset();
        reset = 1'b0;
        #1;
        chk("rst_out_val", out_val, 1'b0);
        chk("rst_out_msg", out_msg, 10'h000);
        chk("rst_in_rdy", in_rdy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Mixed tags: accumulate under backpressure, then drain
        mix = '{10'h0aa, 10'h1bb, 10'h2cc, 10'h3dd, 10'h0ee, 10'h1ff, 10'h2ab, 10'h3cd};
        obs.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, mix[i], 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 10'h000, 1'b1);
        chk("mix_count", obs.size(), 8);
        chk("mix_t0", (pos(10'h0aa) >= 0) && (pos(10'h0aa) < pos(10'h0ee)), 1);
        chk("mix_t1", (pos(10'h1bb) >= 0) && (pos(10'h1bb) < pos(10'h1ff)), 1);
        chk("mix_t2", (pos(10'h2cc) >= 0) && (pos(10'h2cc) < pos(10'h2ab)), 1);
        chk("mix_t3", (pos(10'h3dd) >= 0) && (pos(10'h3dd) < pos(10'h3cd)), 1);
        diff = 0;
        for (int i = 0; i < 8; i++) if (obs[i] !== mix[i]) diff = 1;
        chk("mix_reordered", diff, 1);

        // Single tag stream: in order, one transfer per cycle after 2-cycle fill
        do_reset();
        obs.delete();
        cnt = 0;
        for (int i = 0; i < 23; i++) begin
            if (i < 20) cycle(1'b1, 10'(10'h011 + i), 1'b1);
            else        cycle(1'b0, 10'h000, 1'b1);
            if (i >= 2 && i <= 21 && last_xfer) cnt++;
        end
        chk("throughput", cnt, 20);
        chk("single_count", obs.size(), 20);
        for (int i = 0; i < 20; i++) chk("single_order", obs[i], 10'(10'h011 + i));

        // Backpressure: one in the register, four filling queue 1
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 10'(10'h101 + i), 1'b0);
        in_val = 1'b1; in_msg = 10'h106; out_rdy = 1'b0;
        #1;
        chk("bp_full_rdy", in_rdy, 1'b0);
        in_msg = 10'h2cc;
        #1;
        chk("bp_other_rdy", in_rdy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 10'h106, 1'b0);
            chk("bp_hold", out_msg, 10'h101);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 10'h000, 1'b1);

        // Asynchronous reset mid-stream
        do_reset();
        cycle(1'b1, 10'h3a1, 1'b0);
        cycle(1'b1, 10'h3a2, 1'b0);
        cycle(1'b1, 10'h0a3, 1'b0);
        cycle(1'b1, 10'h1a4, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_val", out_val, 1'b0);
        chk("arst_out_msg", out_msg, 10'h000);
        chk("arst_in_rdy", in_rdy, 1'b1);
        model_reset();
        in_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 10'h000, 1'b1);
            if (out_val) cnt++;
        end
        chk("arst_no_stale", cnt, 0);

        // Random traffic against the model, recorded for the determinism replay
        do_reset();
        trace.delete();
        rec  = 1;
        pv   = 0;
        pacc = 0;
        held = '0;
        for (int i = 0; i < 300; i++) begin
            st_v[i] = ($urandom_range(0, 99) < 70);
            if (pv && !pacc) st_v[i] = 1'b1;
            else             held = 10'($urandom_range(0, 1023));
            st_m[i] = held;
            st_r[i] = ($urandom_range(0, 99) < 60);
            pv   = st_v[i];
            pacc = st_v[i] && (mq[int'(held[9:8])].size() < 4);
            cycle(st_v[i], st_m[i], st_r[i]);
        end
        trace1 = trace;

        // Determinism: identical stimulus after reset gives identical outputs cycle-for-cycle
        do_reset();
        trace.delete();
        for (int i = 0; i < 300; i++) cycle(st_v[i], st_m[i], st_r[i]);
        rec = 0;
        chk("determinism_len", trace.size(), trace1.size());
        diff = 0;
        for (int i = 0; i < 300; i++) if (trace[i] !== trace1[i]) diff++;
        chk("determinism", diff, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
